// File: rtl/uart_ms_pkg.sv
// uart_ms_pkg: parser states and host command bytes for the UART bus bridge
package uart_ms_pkg;
  typedef enum logic [2:0] {IDLE, ESC, ADDR_HI, ADDR_LO, DATA, BUS} state_t;
  localparam logic [7:0] ESC_CHAR  = 8'hFF;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_RESET = 8'h53;
  localparam logic [7:0] CMD_CLEAR = 8'h43;
endpackage

// File: rtl/uart_ms_phy.sv
// uart_ms_phy: 8N1 serialiser/deserialiser, DIV clocks per bit
module uart_ms_phy #(
  parameter int DIV = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  input  logic       i_tx_load,
  input  logic [7:0] i_tx_data,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_tx,
  output logic       o_tx_busy
);
  localparam int CW = $clog2(DIV + 1);
  logic [2:0]    rx_sync;
  logic          rx_busy;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;
  assign o_tx = tx_sh[0];
  // rx_sync[1] is the synchronised line, rx_sync[2] its previous value for edge detection
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_sync    <= '1;
      rx_busy    <= 1'b0;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
    end else begin
      rx_sync    <= {rx_sync[1:0], i_rx};
      o_rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (rx_sync[2] & ~rx_sync[1]) begin
          rx_busy <= 1'b1;
          rx_cnt  <= CW'(DIV / 2 - 1);
          rx_bit  <= '0;
        end
      end else if (rx_cnt == '0) begin
        rx_cnt <= CW'(DIV - 1);
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd9) begin
          rx_busy    <= 1'b0;
          o_rx_valid <= rx_sync[1];
        end else if (rx_bit != 4'd0) o_rx_data <= {rx_sync[1], o_rx_data[7:1]};
      end else rx_cnt <= rx_cnt - 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_sh     <= '1;
      o_tx_busy <= 1'b0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
    end else if (!o_tx_busy) begin
      if (i_tx_load) begin
        tx_sh     <= {i_tx_data, 1'b0};
        o_tx_busy <= 1'b1;
        tx_cnt    <= CW'(DIV - 1);
        tx_bit    <= '0;
      end
    end else if (tx_cnt == '0) begin
      tx_sh  <= {1'b1, tx_sh[8:1]};
      tx_cnt <= CW'(DIV - 1);
      tx_bit <= tx_bit + 4'd1;
      if (tx_bit == 4'd9) o_tx_busy <= 1'b0;
    end else tx_cnt <= tx_cnt - 1'b1;
  end
endmodule

// File: rtl/uart_master_slave.sv
// uart_master_slave: UART console port plus escaped bus-master/CPU-reset commands.
// Define UART_MS_RX_INT_EN to drive o_int from the console receive buffer.
module uart_master_slave
  import uart_ms_pkg::*;
#(
  parameter int BAUDRATE = 1152000,
  parameter int SYS_FREQ = 25000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_master_data,
  output logic [7:0]  o_master_data,
  output logic [15:0] o_master_addr,
  input  logic        i_master_ack,
  output logic        o_master_we,
  output logic        o_master_cs,
  input  logic [7:0]  i_slave_data,
  output logic [7:0]  o_slave_data,
  input  logic        i_slave_addr,
  output logic        o_slave_ack,
  input  logic        i_slave_we,
  input  logic        i_slave_cs,
  output logic        o_int,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  output logic        o_reset
);
  localparam int DIV = SYS_FREQ / BAUDRATE;
  state_t     state;
  logic [7:0] rx_data, pend_b, rx_byte, mreply_b, in_b, tx_data;
  logic       rx_strobe, pend_v, rx_valid, mreply_v, cs_q;
  logic       in_v, cs_rise, slave_wr, tx_load, tx_busy_phy, tx_busy;
  uart_ms_phy #(.DIV(DIV)) u_phy (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rx       (i_uart_rx),
    .i_tx_load  (tx_load),
    .i_tx_data  (tx_data),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_strobe),
    .o_tx       (o_uart_tx),
    .o_tx_busy  (tx_busy_phy)
  );
  assign in_v         = (state != BUS) & (pend_v | rx_strobe);
  assign in_b         = pend_v ? pend_b : rx_data;
  assign cs_rise      = i_slave_cs & ~cs_q;
  assign slave_wr     = cs_rise & i_slave_we & i_slave_addr;
  assign tx_busy      = tx_busy_phy | mreply_v;
  assign tx_load      = ~tx_busy_phy & (mreply_v | slave_wr);
  assign tx_data      = mreply_v ? mreply_b : i_slave_data;
  assign o_slave_data = i_slave_addr ? rx_byte : {6'b0, tx_busy, rx_valid};
  assign o_slave_ack  = i_slave_cs;
`ifdef UART_MS_RX_INT_EN
  assign o_int = rx_valid;
`else
  assign o_int = 1'b0;
`endif
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      pend_v        <= 1'b0;
      pend_b        <= '0;
      rx_valid      <= 1'b0;
      rx_byte       <= '0;
      mreply_v      <= 1'b0;
      mreply_b      <= '0;
      cs_q          <= 1'b0;
      o_master_cs   <= 1'b0;
      o_master_we   <= 1'b0;
      o_master_addr <= '0;
      o_master_data <= '0;
      o_reset       <= 1'b0;
    end else begin
      cs_q <= i_slave_cs;
      if (cs_rise & ~i_slave_we & i_slave_addr) rx_valid <= 1'b0;
      if (tx_load & mreply_v) mreply_v <= 1'b0;
      // a byte landing during a bus access waits in pend until the access completes
      if (state == BUS && rx_strobe) begin
        pend_v <= 1'b1;
        pend_b <= rx_data;
      end else if (in_v) pend_v <= 1'b0;
      if (in_v) begin
        case (state)
          IDLE: begin
            if (in_b == ESC_CHAR) state <= ESC;
            else begin
              rx_valid <= 1'b1;
              rx_byte  <= in_b;
            end
          end
          ESC: begin
            state <= IDLE;
            if (in_b == ESC_CHAR) begin
              rx_valid <= 1'b1;
              rx_byte  <= in_b;
            end else if (in_b == CMD_WRITE || in_b == CMD_READ) begin
              o_master_we <= in_b == CMD_WRITE;
              state       <= ADDR_HI;
            end else if (in_b == CMD_RESET) o_reset <= 1'b1;
            else if (in_b == CMD_CLEAR) o_reset <= 1'b0;
          end
          ADDR_HI: begin
            o_master_addr[15:8] <= in_b;
            state               <= ADDR_LO;
          end
          ADDR_LO: begin
            o_master_addr[7:0] <= in_b;
            o_master_cs        <= ~o_master_we;
            state              <= o_master_we ? DATA : BUS;
          end
          DATA: begin
            o_master_data <= in_b;
            o_master_cs   <= 1'b1;
            state         <= BUS;
          end
          default: state <= state;
        endcase
      end
      if (state == BUS && i_master_ack) begin
        o_master_cs <= 1'b0;
        state       <= IDLE;
        if (!o_master_we) begin
          mreply_v <= 1'b1;
          mreply_b <= i_master_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_master_slave.sv
// tb_uart_master_slave: directed and randomized host/CPU/bus traffic against a behavioural model
module tb_uart_master_slave;
  localparam int DIV = 16;
`ifdef UART_MS_RX_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_master_data = '0;
  logic [7:0]  o_master_data;
  logic [15:0] o_master_addr;
  logic        i_master_ack = 1'b0;
  logic        o_master_we, o_master_cs;
  logic [7:0]  i_slave_data = '0;
  logic [7:0]  o_slave_data;
  logic        i_slave_addr = 1'b0;
  logic        o_slave_ack;
  logic        i_slave_we = 1'b0;
  logic        i_slave_cs = 1'b0;
  logic        o_int;
  logic        i_uart_rx = 1'b1;
  logic        o_uart_tx;
  logic        o_reset;
  int          vectors = 0;
  int          miscompares = 0;
  logic [9:0]  tx_q[$];
  logic [7:0]  rd, b, d, last;
  logic [15:0] a;
  logic        exp_reset;
  int          op, n;

  always #5 i_clk = ~i_clk;

  uart_master_slave #(.BAUDRATE(1), .SYS_FREQ(16)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_master_data (i_master_data),
    .o_master_data (o_master_data),
    .o_master_addr (o_master_addr),
    .i_master_ack  (i_master_ack),
    .o_master_we   (o_master_we),
    .o_master_cs   (o_master_cs),
    .i_slave_data  (i_slave_data),
    .o_slave_data  (o_slave_data),
    .i_slave_addr  (i_slave_addr),
    .o_slave_ack   (o_slave_ack),
    .i_slave_we    (i_slave_we),
    .i_slave_cs    (i_slave_cs),
    .o_int         (o_int),
    .i_uart_rx     (i_uart_rx),
    .o_uart_tx     (o_uart_tx),
    .o_reset       (o_reset)
  );

  // serial line monitor: full 10-bit frames, start bit in bit 0
  initial forever begin
    logic [9:0] f;
    @(negedge o_uart_tx);
    repeat (DIV / 2) @(posedge i_clk);
    #1 f[0] = o_uart_tx;
    for (int i = 1; i < 10; i++) begin
      repeat (DIV) @(posedge i_clk);
      #1 f[i] = o_uart_tx;
    end
    tx_q.push_back(f);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic stop_bit = 1'b1);
    logic [9:0] f;
    f = {stop_bit, v, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_uart_rx = f[i];
      tick(DIV);
    end
    i_uart_rx = 1'b1;
  endtask

  task automatic cpu(input logic we, input logic ad, input logic [7:0] wd, output logic [7:0] r);
    i_slave_cs = 1'b1; i_slave_we = we; i_slave_addr = ad; i_slave_data = wd;
    #1 r = o_slave_data;
    chk("slave_ack", {15'b0, o_slave_ack}, 16'd1);
    tick(1);
    i_slave_cs = 1'b0; i_slave_we = 1'b0; i_slave_addr = 1'b0;
    tick(1);
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] v);
    int k = 0;
    while (tx_q.size() == 0 && k < 14 * DIV) begin tick(1); k++; end
    if (tx_q.size() == 0) chk({tag, "_timeout"}, 16'(tx_q.size()), 16'd1);
    else chk(tag, {6'b0, tx_q.pop_front()}, {6'b0, 1'b1, v, 1'b0});
  endtask

  task automatic wait_cs();
    int k = 0;
    while (!o_master_cs && k < 4 * DIV) begin tick(1); k++; end
    chk("cs_assert", {15'b0, o_master_cs}, 16'd1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_tx"}, {15'b0, o_uart_tx}, 16'd1);
    chk({tag, "_cs"}, {15'b0, o_master_cs}, 16'd0);
    chk({tag, "_we"}, {15'b0, o_master_we}, 16'd0);
    chk({tag, "_addr"}, o_master_addr, 16'h0000);
    chk({tag, "_data"}, {8'b0, o_master_data}, 16'h0000);
    chk({tag, "_reset"}, {15'b0, o_reset}, 16'd0);
    chk({tag, "_int"}, {15'b0, o_int}, 16'd0);
    chk({tag, "_status"}, {8'b0, o_slave_data}, 16'h0000);
  endtask

  task automatic console_check(input string tag, input logic [7:0] v);
    logic [7:0] r;
    chk({tag, "_int"}, {15'b0, o_int}, {15'b0, INT_EN});
    cpu(1'b0, 1'b0, 8'h00, r);
    chk({tag, "_status"}, {8'b0, r}, 16'h0001);
    cpu(1'b0, 1'b1, 8'h00, r);
    chk({tag, "_data"}, {8'b0, r}, {8'b0, v});
    cpu(1'b0, 1'b0, 8'h00, r);
    chk({tag, "_status_after"}, {8'b0, r}, 16'h0000);
    chk({tag, "_int_after"}, {15'b0, o_int}, 16'd0);
  endtask

  task automatic bus_write(input logic [15:0] ad, input logic [7:0] v, input int lat);
    send_byte(8'hFF); send_byte(8'h57); send_byte(ad[15:8]); send_byte(ad[7:0]); send_byte(v);
    wait_cs();
    for (int i = 0; i <= lat; i++) begin
      chk("wr_cs_hold", {15'b0, o_master_cs}, 16'd1);
      chk("wr_we", {15'b0, o_master_we}, 16'd1);
      chk("wr_addr", o_master_addr, ad);
      chk("wr_data", {8'b0, o_master_data}, {8'b0, v});
      if (i < lat) tick(1);
    end
    i_master_ack = 1'b1;
    tick(1);
    i_master_ack = 1'b0;
    chk("wr_cs_drop", {15'b0, o_master_cs}, 16'd0);
  endtask

  task automatic bus_read(input logic [15:0] ad, input logic [7:0] v, input int lat);
    send_byte(8'hFF); send_byte(8'h52); send_byte(ad[15:8]); send_byte(ad[7:0]);
    wait_cs();
    i_master_data = v;
    for (int i = 0; i <= lat; i++) begin
      chk("rd_cs_hold", {15'b0, o_master_cs}, 16'd1);
      chk("rd_we", {15'b0, o_master_we}, 16'd0);
      chk("rd_addr", o_master_addr, ad);
      if (i < lat) tick(1);
    end
    i_master_ack = 1'b1;
    tick(1);
    i_master_ack = 1'b0;
    i_master_data = 8'h00;
    chk("rd_cs_drop", {15'b0, o_master_cs}, 16'd0);
    expect_tx("rd_reply", v);
  endtask

  initial begin
    tick(3);
    check_idle("reset");
    i_reset = 1'b0;
    tick(2);
    send_byte(8'h41);
    console_check("rx41", 8'h41);
    cpu(1'b1, 1'b1, 8'h5A, rd);
    tick(2);
    cpu(1'b0, 1'b0, 8'h00, rd);
    chk("tx_busy_status", {8'b0, rd}, 16'h0002);
    expect_tx("tx5a", 8'h5A);
    tick(DIV);
    cpu(1'b0, 1'b0, 8'h00, rd);
    chk("tx_idle_status", {8'b0, rd}, 16'h0000);
    cpu(1'b1, 1'b1, 8'hA1, rd);
    cpu(1'b1, 1'b1, 8'hB2, rd);
    expect_tx("tx_first", 8'hA1);
    tick(12 * DIV);
    chk("tx_busy_ignored", 16'(tx_q.size()), 16'd0);
    bus_write(16'h1234, 8'hAB, 2);
    cpu(1'b0, 1'b0, 8'h00, rd);
    chk("wr_no_console", {8'b0, rd}, 16'h0000);
    bus_read(16'h0010, 8'h99, 3);
    send_byte(8'hFF); send_byte(8'h53);
    chk("cmd_s", {15'b0, o_reset}, 16'd1);
    send_byte(8'hFF); send_byte(8'h43);
    chk("cmd_c", {15'b0, o_reset}, 16'd0);
    send_byte(8'hFF); send_byte(8'hFF);
    chk("ffff_no_cs", {15'b0, o_master_cs}, 16'd0);
    console_check("ffff", 8'hFF);
    send_byte(8'hFF); send_byte(8'h11);
    cpu(1'b0, 1'b0, 8'h00, rd);
    chk("esc_unknown", {8'b0, rd}, 16'h0000);
    chk("esc_unknown_cs", {15'b0, o_master_cs}, 16'd0);
    send_byte(8'h33, 1'b0);
    tick(DIV);
    cpu(1'b0, 1'b0, 8'h00, rd);
    chk("bad_stop", {8'b0, rd}, 16'h0000);
    send_byte(8'h10); send_byte(8'h20);
    console_check("overwrite", 8'h20);
    exp_reset = 1'b0;
    for (int it = 0; it < 14; it++) begin
      op = int'($urandom_range(0, 4));
      if (op == 0) begin
        n = int'($urandom_range(1, 2));
        for (int j = 0; j < n; j++) begin
          b = 8'($urandom_range(0, 254));
          last = b;
          send_byte(b);
        end
        console_check("rnd_console", last);
      end else if (op == 1) begin
        a = 16'($urandom); d = 8'($urandom);
        bus_write(a, d, int'($urandom_range(0, 3)));
      end else if (op == 2) begin
        a = 16'($urandom); d = 8'($urandom);
        bus_read(a, d, int'($urandom_range(0, 4)));
      end else if (op == 3) begin
        d = 8'($urandom);
        cpu(1'b1, 1'b1, d, rd);
        expect_tx("rnd_tx", d);
        tick(DIV);
      end else begin
        exp_reset = 1'($urandom);
        send_byte(8'hFF); send_byte(exp_reset ? 8'h53 : 8'h43);
      end
      chk("rnd_reset_level", {15'b0, o_reset}, {15'b0, exp_reset});
    end
    send_byte(8'hFF); send_byte(8'h53);
    chk("pre_rst_s", {15'b0, o_reset}, 16'd1);
    fork
      send_byte(8'hFF);
      begin
        tick(3 * DIV + 4);
        i_reset = 1'b1;
        tick(1);
        check_idle("rst_rx");
        i_reset = 1'b0;
      end
    join
    tick(DIV);
    cpu(1'b0, 1'b0, 8'h00, rd);
    chk("rst_rx_dropped", {8'b0, rd}, 16'h0000);
    send_byte(8'h41);
    console_check("post_rst_rx", 8'h41);
    send_byte(8'hFF); send_byte(8'h57); send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
    wait_cs();
    i_reset = 1'b1;
    tick(1);
    check_idle("rst_bus");
    i_reset = 1'b0;
    tick(2);
    bus_read(16'h0020, 8'h3C, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
